// File: rtl/sopc_led_pio_pkg.sv
// Register map shared by the LED PIO top level and its testbench.
package sopc_led_pio_pkg;

  localparam int ADDR_W = 3;

  localparam logic [ADDR_W-1:0] ADDR_DATA     = 3'd0;
  localparam logic [ADDR_W-1:0] ADDR_MODE     = 3'd1;
  localparam logic [ADDR_W-1:0] ADDR_PRESCALE = 3'd2;
  localparam logic [ADDR_W-1:0] ADDR_OUTSET   = 3'd3;
  localparam logic [ADDR_W-1:0] ADDR_OUTCLEAR = 3'd4;
  localparam logic [ADDR_W-1:0] ADDR_STATUS   = 3'd5;

endpackage

// File: rtl/led_blink_prescaler.sv
// Shared blink time base: down-counter with terminal-count reload and a phase bit
// that toggles each half-period of (load_val + 1) clk cycles.
module led_blink_prescaler #(
  parameter int                  PRESC_W   = 24,
  parameter logic [PRESC_W-1:0]  CNT_RESET = '0
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               load,
  input  logic [PRESC_W-1:0] load_val,
  output logic               phase
);

  logic [PRESC_W-1:0] cnt;

  // load_val always carries the effective prescale: the new value on a load, else the current one.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt   <= CNT_RESET;
      phase <= 1'b0;
    end else if (load) begin
      cnt   <= load_val;
      phase <= 1'b0;
    end else if (load_val == '0) begin
      cnt   <= '0;
      phase <= 1'b1;
    end else if (cnt == '0) begin
      cnt   <= load_val;
      phase <= ~phase;
    end else begin
      cnt   <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/sopc_led_pio_blink.sv
// Avalon-MM LED output PIO with set/clear writes, per-channel blink and readback.
module sopc_led_pio_blink
  import sopc_led_pio_pkg::*;
#(
  parameter int          WIDTH       = 8,
  parameter int          PRESC_W     = 24,
  parameter logic [31:0] DATA_RESET  = 32'd0,
  parameter int unsigned PRESC_RESET = 12_500_000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [2:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic [WIDTH-1:0]  out_port
);

  localparam logic [WIDTH-1:0]   DATA_INIT  = WIDTH'(DATA_RESET);
  localparam logic [PRESC_W-1:0] PRESC_INIT = PRESC_W'(PRESC_RESET);

  logic [WIDTH-1:0]   data_q;
  logic [WIDTH-1:0]   mode_q;
  logic [PRESC_W-1:0] presc_q;
  logic [WIDTH-1:0]   out_q;
  logic               wr;
  logic               presc_wr;
  logic [WIDTH-1:0]   wdat;
  logic [PRESC_W-1:0] wpre;
  logic [PRESC_W-1:0] presc_eff;
  logic               phase;
  logic               unused_wdata;

  assign wr        = chipselect && !write_n;
  assign presc_wr  = wr && (address == ADDR_PRESCALE);
  assign wdat      = writedata[WIDTH-1:0];
  assign wpre      = writedata[PRESC_W-1:0];
  assign presc_eff = presc_wr ? wpre : presc_q;
  assign unused_wdata = ^writedata;

  led_blink_prescaler #(
    .PRESC_W   (PRESC_W),
    .CNT_RESET (PRESC_INIT)
  ) u_presc (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (presc_wr),
    .load_val (presc_eff),
    .phase    (phase)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      data_q  <= DATA_INIT;
      mode_q  <= '0;
      presc_q <= PRESC_INIT;
      out_q   <= '0;
    end else begin
      if (wr) begin
        case (address)
          ADDR_DATA:     data_q  <= wdat;
          ADDR_MODE:     mode_q  <= wdat;
          ADDR_PRESCALE: presc_q <= wpre;
          ADDR_OUTSET:   data_q  <= data_q | wdat;
          ADDR_OUTCLEAR: data_q  <= data_q & ~wdat;
          default:       ;
        endcase
      end
      // Uses pre-write register values, giving one clk of latency from a commit.
      out_q <= data_q & (~mode_q | {WIDTH{phase}});
    end
  end

  assign out_port = out_q;

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:     readdata[WIDTH-1:0]   = data_q;
      ADDR_MODE:     readdata[WIDTH-1:0]   = mode_q;
      ADDR_PRESCALE: readdata[PRESC_W-1:0] = presc_q;
      ADDR_STATUS:   readdata[WIDTH-1:0]   = out_q;
      default:       readdata              = '0;
    endcase
  end

endmodule

// File: tb/tb_sopc_led_pio_blink.sv
// Directed self-checking bench for the LED PIO, plus a WIDTH=32 / PRESC_W=1 instance.
module tb_sopc_led_pio_blink;
  import sopc_led_pio_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  out_port;
  logic [31:0] readdata_w;
  logic [31:0] out_port_w;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sopc_led_pio_blink dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port)
  );

  sopc_led_pio_blink #(.WIDTH(32), .PRESC_W(1)) dut_wide (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata_w),
    .out_port   (out_port_w)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Commits on the next posedge; returns 1 time unit after that edge.
  task automatic bus_wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_rd(input logic [2:0] a, output logic [31:0] d);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    #1;
    d = readdata;
    chipselect = 1'b0;
  endtask

  logic [31:0] r;
  logic [7:0]  exp_out;

  initial begin
    reset_n = 1'b0; address = ADDR_DATA; chipselect = 1'b1; write_n = 1'b0;
    writedata = 32'hFFFF_FFFF;
    repeat (2) @(posedge clk);
    #1;
    chipselect = 1'b0; write_n = 1'b1;
    chk("rst_out", {24'd0, out_port}, 32'h0);
    chk("rst_out_wide", out_port_w, 32'h0);
    bus_rd(ADDR_DATA, r);     chk("rst_data", r, 32'h0);
    bus_rd(ADDR_MODE, r);     chk("rst_mode", r, 32'h0);
    bus_rd(ADDR_PRESCALE, r); chk("rst_presc", r, 32'd12_500_000);
    @(negedge clk);
    reset_n = 1'b1;

    // static write, one clk latency
    bus_wr(ADDR_DATA, 32'hFFFF_FFA5);
    chk("static_lat0", {24'd0, out_port}, 32'h0);
    @(posedge clk); #1;
    chk("static_lat1", {24'd0, out_port}, 32'hA5);
    chk("static_wide", out_port_w, 32'hFFFF_FFA5);
    bus_rd(ADDR_DATA, r); chk("static_rd", r, 32'h0000_00A5);

    // set / clear
    bus_wr(ADDR_DATA, 32'h0F);
    bus_wr(ADDR_OUTSET, 32'h30);
    bus_rd(ADDR_DATA, r); chk("outset", r, 32'h3F);
    bus_wr(ADDR_OUTCLEAR, 32'h05);
    bus_rd(ADDR_DATA, r); chk("outclear", r, 32'h3A);
    @(posedge clk); #1;
    chk("setclr_out", {24'd0, out_port}, 32'h3A);
    bus_rd(ADDR_OUTSET, r);   chk("rd_outset", r, 32'h0);
    bus_rd(ADDR_OUTCLEAR, r); chk("rd_outclear", r, 32'h0);
    bus_wr(3'd6, 32'hFF);
    bus_rd(3'd6, r);          chk("rd_off6", r, 32'h0);
    bus_rd(ADDR_DATA, r);     chk("wr_off6_ignored", r, 32'h3A);

    // blink: PRESCALE commits at edge 0, phase toggles every 4 edges, out lags 1 edge
    bus_wr(ADDR_PRESCALE, 32'd3);
    bus_wr(ADDR_DATA, 32'hFF);
    bus_wr(ADDR_MODE, 32'h81);
    bus_rd(ADDR_PRESCALE, r); chk("rd_presc", r, 32'd3);
    bus_rd(ADDR_MODE, r);     chk("rd_mode", r, 32'h81);
    for (int n = 3; n <= 16; n++) begin
      @(posedge clk); #1;
      exp_out = (((n - 1) / 4) % 2 == 1) ? 8'hFF : 8'h7E;
      chk($sformatf("blink_e%0d", n), {24'd0, out_port}, {24'd0, exp_out});
      bus_rd(ADDR_STATUS, r);
      chk($sformatf("status_e%0d", n), r, {24'd0, exp_out});
    end

    // PRESCALE rewritten on the terminal-count edge: no toggle there
    bus_wr(ADDR_DATA, 32'h01);
    bus_wr(ADDR_MODE, 32'h01);
    bus_wr(ADDR_PRESCALE, 32'd3);
    repeat (3) @(posedge clk);
    bus_wr(ADDR_PRESCALE, 32'd3);
    @(posedge clk); #1;
    chk("tc_e5", {24'd0, out_port}, 32'h0);
    repeat (3) @(posedge clk); #1;
    chk("tc_e8", {24'd0, out_port}, 32'h0);
    @(posedge clk); #1;
    chk("tc_e9", {24'd0, out_port}, 32'h1);

    // PRESCALE = 0: blinking channels follow DATA
    bus_wr(ADDR_PRESCALE, 32'd0);
    bus_wr(ADDR_DATA, 32'h5A);
    bus_wr(ADDR_MODE, 32'hFF);
    repeat (3) @(posedge clk); #1;
    chk("presc0_out", {24'd0, out_port}, 32'h5A);
    repeat (5) @(posedge clk); #1;
    chk("presc0_hold", {24'd0, out_port}, 32'h5A);

    // reset while phase = 1
    bus_wr(ADDR_PRESCALE, 32'd3);
    bus_wr(ADDR_DATA, 32'hFF);
    repeat (4) @(posedge clk); #1;
    chk("pre_rst_phase1", {24'd0, out_port}, 32'hFF);
    @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst_out", {24'd0, out_port}, 32'h0);
    bus_rd(ADDR_DATA, r);     chk("midrst_data", r, 32'h0);
    bus_rd(ADDR_MODE, r);     chk("midrst_mode", r, 32'h0);
    bus_rd(ADDR_PRESCALE, r); chk("midrst_presc", r, 32'd12_500_000);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(posedge clk); #1;
    chk("post_rst_out", {24'd0, out_port}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
